// File: rtl/eqed_inject_ctrl_if.sv
// eqed_inject_ctrl_if -- bundles the capture/injection control bus of
// eqed_inject_ctrl. The master side drives the run requests, the injection
// select and the observed data. The slave side (the controller) returns the
// injection vector, the status flags, the signatures and the log.
interface eqed_inject_ctrl_if #(
    parameter int N_FF   = 8,
    parameter int SEL_W  = 4,
    parameter int IN_W   = 2,
    parameter int OUT_W  = 3,
    parameter int MISR_W = 6,
    parameter int CNT_W  = 10
);
    logic               start;
    logic               sel_valid;
    logic [SEL_W-1:0]   sel;
    logic [IN_W-1:0]    in_data;
    logic [OUT_W-1:0]   out_data;
    logic [MISR_W-1:0]  exp_in_sig;
    logic [MISR_W-1:0]  exp_out_sig;
    logic [N_FF-1:0]    inject_vec;
    logic               injected;
    logic               busy;
    logic               done;
    logic               match;
    logic [MISR_W-1:0]  in_sig;
    logic [MISR_W-1:0]  out_sig;
    logic [CNT_W-1:0]   cycle_count;
    logic [SEL_W-1:0]   inj_idx;
    logic [CNT_W-1:0]   inj_cycle;

    modport master (
        output start, sel_valid, sel, in_data, out_data, exp_in_sig, exp_out_sig,
        input  inject_vec, injected, busy, done, match, in_sig, out_sig,
               cycle_count, inj_idx, inj_cycle
    );

    modport slave (
        input  start, sel_valid, sel, in_data, out_data, exp_in_sig, exp_out_sig,
        output inject_vec, injected, busy, done, match, in_sig, out_sig,
               cycle_count, inj_idx, inj_cycle
    );
endinterface

// File: rtl/eqed_inject_ctrl.sv
// eqed_inject_ctrl -- single-fault bit-flip injection controller with
// input/output MISR signatures over a fixed capture window.
// A run lasts WINDOW cycles. At most one injection happens per run. At the
// end of the run, both signatures are compared with the expected values.
// Optional build macro: EQED_INJECT_LOG_EN adds a log of the injection target
// and the injection cycle. Without it, both log outputs read 0.
module eqed_inject_ctrl #(
    parameter int N_FF   = 8,
    parameter int SEL_W  = 4,
    parameter int IN_W   = 2,
    parameter int OUT_W  = 3,
    parameter int MISR_W = 6,
    parameter int WINDOW = 5,
    parameter int CNT_W  = 10
) (
    input  logic                i_clk,
    input  logic                i_rst,
    eqed_inject_ctrl_if.slave   bus
);
    localparam int WIN_W = $clog2(WINDOW + 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
    localparam logic [SEL_W-1:0]  SEL_LIMIT = SEL_W'(N_FF);
    localparam logic [MISR_W-1:0] SEED      = {{(MISR_W-1){1'b0}}, 1'b1};
    localparam logic [N_FF-1:0]   ONE_HOT0  = {{(N_FF-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_run_entry;
    logic                w_run_last;
    logic [WIN_W-1:0]    r_win;
    logic [MISR_W-1:0]   r_in_sig;
    logic [MISR_W-1:0]   r_out_sig;
    logic [MISR_W-1:0]   w_in_nxt;
    logic [MISR_W-1:0]   w_out_nxt;
    logic                r_injected;
    logic                r_match;
    logic [CNT_W-1:0]    r_cycle_count;
    logic [N_FF-1:0]     w_inject_vec;
    logic                w_inj_fire;

    // One MISR step: shift up with a two-tap feedback into bit 0, then fold in
    // the zero-extended data word.
    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] s,
                                                    input logic [MISR_W-1:0] d);
        return {s[MISR_W-2:0], s[MISR_W-1] ^ s[MISR_W-2]} ^ d;
    endfunction

    assign w_in_nxt  = misr_step(r_in_sig,  MISR_W'(bus.in_data));
    assign w_out_nxt = misr_step(r_out_sig, MISR_W'(bus.out_data));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Flags mark run entry and the last run cycle. A start
    // pulse during RUN is ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_run_entry = 1'b0;
        w_run_last  = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    w_state_nxt = ST_RUN;
                    w_run_entry = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            ST_RUN: begin
                if (r_win == WIN_LAST) begin
                    w_state_nxt = ST_DONE;
                    w_run_last  = 1'b1;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // One-shot injection select. It is live only in RUN before the first
    // injection, and only for targets that are in range.
    always_comb begin
        w_inject_vec = {N_FF{1'b0}};
        if ((r_state == ST_RUN) && !r_injected && bus.sel_valid && (bus.sel < SEL_LIMIT)) begin
            w_inject_vec = ONE_HOT0 << bus.sel;
        end else begin
            w_inject_vec = {N_FF{1'b0}};
        end
    end

    assign w_inj_fire = |w_inject_vec;

    // Run datapath. Run entry loads the seeds and clears the flags. Each RUN
    // cycle steps the MISRs and the window counter. On the last RUN cycle,
    // match registers the compare of the final signatures.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_in_sig   <= SEED;
            r_out_sig  <= SEED;
            r_win      <= {WIN_W{1'b0}};
            r_injected <= 1'b0;
            r_match    <= 1'b0;
        end else if (w_run_entry) begin
            r_in_sig   <= SEED;
            r_out_sig  <= SEED;
            r_win      <= {WIN_W{1'b0}};
            r_injected <= 1'b0;
            r_match    <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_in_sig  <= w_in_nxt;
            r_out_sig <= w_out_nxt;
            r_win     <= r_win + WIN_W'(1);
            if (w_inj_fire) begin
                r_injected <= 1'b1;
            end
            if (w_run_last) begin
                r_match <= (w_in_nxt == bus.exp_in_sig) && (w_out_nxt == bus.exp_out_sig);
            end
        end
    end

    // Free-running cycle counter. It starts at 1 after reset and sticks at
    // all-ones.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cycle_count <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (r_cycle_count != CNT_MAX) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
        end
    end

`ifdef EQED_INJECT_LOG_EN
    logic [SEL_W-1:0] r_inj_idx;
    logic [CNT_W-1:0] r_inj_cycle;

    // Injection log. It captures the target and the cycle of the one injection
    // in the run, and clears on each run entry.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_run_entry) begin
            r_inj_idx   <= {SEL_W{1'b0}};
            r_inj_cycle <= {CNT_W{1'b0}};
        end else if (w_inj_fire) begin
            r_inj_idx   <= bus.sel;
            r_inj_cycle <= r_cycle_count;
        end
    end

    assign bus.inj_idx   = r_inj_idx;
    assign bus.inj_cycle = r_inj_cycle;
`else
    assign bus.inj_idx   = {SEL_W{1'b0}};
    assign bus.inj_cycle = {CNT_W{1'b0}};
`endif

    assign bus.inject_vec  = w_inject_vec;
    assign bus.injected    = r_injected;
    assign bus.busy        = (r_state == ST_RUN);
    assign bus.done        = (r_state == ST_DONE);
    assign bus.match       = r_match;
    assign bus.in_sig      = r_in_sig;
    assign bus.out_sig     = r_out_sig;
    assign bus.cycle_count = r_cycle_count;
endmodule

// File: tb/tb_eqed_inject_ctrl.sv
// tb_eqed_inject_ctrl -- directed and random stimulus for eqed_inject_ctrl.
// A behavioural run model predicts every output, and the bench compares the
// DUT against it on every cycle.
module tb_eqed_inject_ctrl;
    localparam int N_FF = 8, SEL_W = 4, IN_W = 2, OUT_W = 3, MISR_W = 6, WINDOW = 5, CNT_W = 10;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   vec08_hits = 0;

    eqed_inject_ctrl_if #(.N_FF(N_FF), .SEL_W(SEL_W), .IN_W(IN_W), .OUT_W(OUT_W),
                          .MISR_W(MISR_W), .CNT_W(CNT_W)) bus ();

    eqed_inject_ctrl #(.N_FF(N_FF), .SEL_W(SEL_W), .IN_W(IN_W), .OUT_W(OUT_W),
                       .MISR_W(MISR_W), .WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model state. Phase: 0 = idle, 1 = running, 2 = finished.
    // left = run cycles still to go.
    int m_phase = 0, m_left = 0, m_in = 1, m_out = 1, m_inj = 0, m_match = 0;
    int m_cnt = 1, m_idx = 0, m_icyc = 0;

    function automatic int misr(input int s, input int d);
        int fb;
        fb = ((s >> (MISR_W - 1)) & 1) ^ ((s >> (MISR_W - 2)) & 1);
        return ((s << 1) & ((1 << MISR_W) - 1)) ^ fb ^ d;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("busy", 32'(bus.busy), (m_phase == 1) ? 1 : 0);
        chk("done", 32'(bus.done), (m_phase == 2) ? 1 : 0);
        chk("match", 32'(bus.match), m_match);
        chk("in_sig", 32'(bus.in_sig), m_in);
        chk("out_sig", 32'(bus.out_sig), m_out);
        chk("cycle_count", 32'(bus.cycle_count), m_cnt);
        chk("injected", 32'(bus.injected), m_inj);
`ifdef EQED_INJECT_LOG_EN
        chk("inj_idx", 32'(bus.inj_idx), m_idx);
        chk("inj_cycle", 32'(bus.inj_cycle), m_icyc);
`else
        chk("inj_idx", 32'(bus.inj_idx), 0);
        chk("inj_cycle", 32'(bus.inj_cycle), 0);
`endif
    endtask

    // Check inject_vec before the edge, step the model, clock once,
    // then check every output.
    task automatic tick();
        int ev;
        #1;
        ev = (m_phase == 1 && m_inj == 0 && bus.sel_valid && int'(bus.sel) < N_FF) ? (1 << bus.sel) : 0;
        chk("inject_vec", 32'(bus.inject_vec), ev);
        if (bus.inject_vec === 8'h08) vec08_hits++;
        if (rst) begin
            m_phase = 0; m_in = 1; m_out = 1; m_cnt = 1; m_inj = 0; m_match = 0; m_idx = 0; m_icyc = 0;
        end else begin
            if (m_phase == 1) begin
                m_in  = misr(m_in,  int'(bus.in_data));
                m_out = misr(m_out, int'(bus.out_data));
                if (ev != 0) begin m_inj = 1; m_idx = int'(bus.sel); m_icyc = m_cnt; end
                m_left--;
                if (m_left == 0) begin
                    m_phase = 2;
                    m_match = (m_in == int'(bus.exp_in_sig) && m_out == int'(bus.exp_out_sig)) ? 1 : 0;
                end
            end else if (bus.start) begin
                m_phase = 1; m_left = WINDOW; m_in = 1; m_out = 1; m_inj = 0; m_match = 0; m_idx = 0; m_icyc = 0;
            end
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.start = 1'b0; bus.sel_valid = 1'b0; bus.sel = 4'd0;
        bus.in_data = 2'd0; bus.out_data = 3'd0;
        bus.exp_in_sig = 6'h21; bus.exp_out_sig = 6'h21;

        // Reset state
        tick(); tick();
        chk("rst_cycle_count", 32'(bus.cycle_count), 1);
        chk("rst_in_sig", 32'(bus.in_sig), 1);
        rst = 1'b0;
        tick();

        // Zero data, matching expectations: done six cycles after start, match = 1
        bus.start = 1'b1; n = 1; tick(); bus.start = 1'b0;
        while (!bus.done && n < 20) begin tick(); n++; end
        chk("done_latency", 32'(n), 6);
        chk("sig_in_21", 32'(bus.in_sig), 32'h21);
        chk("sig_out_21", 32'(bus.out_sig), 32'h21);
        chk("match_hit", 32'(bus.match), 1);
        tick();
        chk("match_hold", 32'(bus.match), 1);

        // Restart from DONE clears match; wrong out expectation gives match = 0
        bus.exp_out_sig = 6'h20;
        bus.start = 1'b1; n = 1; tick(); bus.start = 1'b0;
        chk("restart_busy", 32'(bus.busy), 1);
        chk("restart_match_clr", 32'(bus.match), 0);
        while (!bus.done && n < 20) begin tick(); n++; end
        chk("miss_done", 32'(bus.done), 1);
        chk("miss_match", 32'(bus.match), 0);

        // sel = 3 held during the whole run: exactly one injection
        bus.sel = 4'd3; bus.sel_valid = 1'b1; vec08_hits = 0;
        bus.start = 1'b1; n = 1; tick(); bus.start = 1'b0;
        while (!bus.done && n < 20) begin tick(); n++; end
        chk("inj_once", 32'(vec08_hits), 1);
        chk("inj_flag", 32'(bus.injected), 1);
`ifdef EQED_INJECT_LOG_EN
        chk("inj_idx_3", 32'(bus.inj_idx), 3);
`endif

        // Restart from DONE clears injected. sel = 8 is out of range: no injection
        bus.sel = 4'd8;
        bus.start = 1'b1; n = 1; tick(); bus.start = 1'b0;
        chk("restart_inj_clr", 32'(bus.injected), 0);
        while (!bus.done && n < 20) begin tick(); n++; end
        chk("oor_injected", 32'(bus.injected), 0);
        bus.sel_valid = 1'b0;

        // start pulsed again inside RUN is ignored
        bus.start = 1'b1; n = 1; tick(); bus.start = 1'b0;
        tick(); n++;
        bus.start = 1'b1; tick(); n++; bus.start = 1'b0;
        while (!bus.done && n < 20) begin tick(); n++; end
        chk("repulse_latency", 32'(n), 6);

        // Reset on RUN cycle 3 aborts the run
        bus.start = 1'b1; tick(); bus.start = 1'b0;
        tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("abort_busy", 32'(bus.busy), 0);
        chk("abort_done", 32'(bus.done), 0);
        chk("abort_in_sig", 32'(bus.in_sig), 1);
        chk("abort_out_sig", 32'(bus.out_sig), 1);
        chk("abort_cnt", 32'(bus.cycle_count), 1);

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            bus.start = ($urandom_range(0, 5) == 0);
            bus.sel_valid = ($urandom_range(0, 3) == 0);
            bus.sel = 4'($urandom_range(0, 15));
            bus.in_data = 2'($urandom);
            bus.out_data = 3'($urandom);
            bus.exp_in_sig = 6'($urandom);
            bus.exp_out_sig = 6'($urandom);
            tick();
        end

        // Idle long enough to reach counter saturation
        rst = 1'b0; bus.start = 1'b0; bus.sel_valid = 1'b0;
        for (int i = 0; i < 1100; i++) tick();
        chk("cnt_saturated", 32'(bus.cycle_count), 32'h3FF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eqed_inject_ctrl.md
EQED_INJECT_CTRL -- requirements
Module: eqed_inject_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- N_FF, 8, number of injection targets (bit-flip mux selects).
- SEL_W, 4, width of the binary target select; SHALL satisfy 2^SEL_W > N_FF.
- IN_W, 2, width of the input data bus compressed into the input signature.
- OUT_W, 3, width of the output data bus compressed into the output signature.
- MISR_W, 6, signature width; SHALL satisfy MISR_W >= max(IN_W, OUT_W) and MISR_W >= 2.
- WINDOW, 5, capture window length in cycles.
- CNT_W, 10, width of the free-running cycle counter.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; all state updates on its rising edge.
- rst, in, 1, synchronous, active-high reset.
- start, in, 1, requests a new capture run.
- sel_valid, in, 1, requests an injection this cycle.
- sel, in, SEL_W, binary index of the injection target.
- in_data, in, IN_W, observed inputs of the design under test.
- out_data, in, OUT_W, observed outputs of the design under test.
- exp_in_sig, in, MISR_W, expected final input signature.
- exp_out_sig, in, MISR_W, expected final output signature.
- inject_vec, out, N_FF, one-hot bit-flip select.
- injected, out, 1, an injection has occurred in the current run.
- busy, out, 1, FSM is in RUN.
- done, out, 1, FSM is in DONE.
- match, out, 1, signature compare result.
- in_sig, out, MISR_W, input MISR state.
- out_sig, out, MISR_W, output MISR state.
- cycle_count, out, CNT_W, cycle counter.
- inj_idx, out, SEL_W, logged injection target index.
- inj_cycle, out, CNT_W, logged injection cycle.

Function
REQ-003 The FSM SHALL have three states: IDLE, RUN, DONE.
- IDLE + start -> RUN.
- RUN: after WINDOW cycles -> DONE.
- DONE + start -> RUN.
- start while in RUN SHALL be ignored.

REQ-004 On each entry to RUN: in_sig and out_sig SHALL load seed 1 (bit0 = 1), the window counter SHALL clear, and injected SHALL clear.

REQ-005 In each RUN cycle each MISR SHALL update with data d of width D:
- next[0] = s[MISR_W-1] ^ s[MISR_W-2] ^ d[0];
- next[k] = s[k-1] ^ d[k] for 1 <= k < D;
- next[k] = s[k-1] for all other k.
The MISRs SHALL hold their value outside RUN.

REQ-006 inject_vec SHALL be combinational and equal onehot(sel) only when all of the following hold: state is RUN, injected is 0, sel_valid is 1, and sel < N_FF. Otherwise inject_vec SHALL be 0.

REQ-007 Injection SHALL be one-shot per run. injected SHALL set on the cycle after any nonzero inject_vec and hold until the next RUN entry. sel >= N_FF SHALL inject nothing and SHALL NOT set injected.

REQ-008 done SHALL assert exactly WINDOW+1 cycles after start is sampled in IDLE or DONE, and SHALL hold until the next start.

REQ-009 On the RUN->DONE transition, match SHALL register (in_sig == exp_in_sig) && (out_sig == exp_out_sig), using the final MISR values. match SHALL hold through DONE and read 0 in RUN and IDLE.

REQ-010 cycle_count SHALL be 1 on the first cycle after reset and increment every cycle. It SHALL saturate at all-ones with no wrap.

REQ-011 busy SHALL be 1 exactly when the state is RUN.

Reset
REQ-012 rst SHALL override start and all other inputs.

REQ-013 Reset values SHALL be: state IDLE, in_sig = out_sig = 1, cycle_count = 1, and injected, match, done, busy, inj_idx, inj_cycle all 0.

REQ-014 rst asserted mid-RUN SHALL abort the run: no done, no match update.

Configuration
REQ-015 With EQED_INJECT_LOG_EN defined, the injection SHALL be logged on the cycle injected sets: inj_idx captures sel and inj_cycle captures cycle_count from the injection cycle. Both SHALL clear on each RUN entry.

REQ-016 Without EQED_INJECT_LOG_EN, inj_idx and inj_cycle SHALL be tied to 0 and no logging registers SHALL exist.

Verification
REQ-017 Defaults, data held at 0, start pulsed once, no injection -> done after 6 cycles, in_sig = out_sig = 6'h21; with exp = 6'h21 on both, match = 1.

REQ-018 As REQ-017 but exp_out_sig = 6'h20 -> done = 1, match = 0.

REQ-019 sel_valid held high with sel = 3 for all of RUN -> inject_vec = 8'h08 for exactly one cycle, then injected = 1; with log enabled, inj_idx = 3 and inj_cycle equals cycle_count at the injection cycle.

REQ-020 sel = 8 with sel_valid = 1 in RUN -> inject_vec stays 0 and injected stays 0.

REQ-021 start re-pulsed in RUN is ignored (done still at +6 cycles from the first start); start in DONE restarts the run and clears injected and match.

REQ-022 rst asserted on RUN cycle 3 -> next cycle IDLE, done = 0, MISRs = 1, cycle_count = 1; force cycle_count near all-ones -> it saturates and does not wrap.
